// File: rtl/xnor_serial_compare_arb.sv
// Bit-serial word-equality controller: round-robin arbitration between two requesters
// sharing one external combinational xnor_gate, LSB-first, AND-accumulated result.
module xnor_serial_compare_arb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inReq0,
    input  logic [WIDTH-1:0] inA0,
    input  logic [WIDTH-1:0] inB0,
    input  logic             inReq1,
    input  logic [WIDTH-1:0] inA1,
    input  logic [WIDTH-1:0] inB1,
    output logic             outGnt0,
    output logic             outGnt1,
    output logic             outBusy,
    output logic             outDone,
    output logic             outEq,
    output logic             outOwner,
    output logic             outXnA,
    output logic             outXnB,
    input  logic             inXnY
);

    localparam int unsigned     IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             busy_q, busy_d, done_q, done_d, eq_q, eq_d;
    logic             xa_q, xa_d, xb_q, xb_d;
    logic             sel;
    logic [WIDTH-1:0] op_a, op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            xa_q    <= 1'b0;
            xb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
        end
    end

    // Operand bits are pre-registered so outXnA/outXnB lead the shift register by one bit.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        xa_d    = 1'b0;
        xb_d    = 1'b0;
        sel     = (inReq0 && inReq1) ? ~last_q : inReq1;
        op_a    = sel ? inA1 : inA0;
        op_b    = sel ? inB1 : inB0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (inReq0 || inReq1) begin
                    state_d = SHIFT;
                    last_d  = sel;
                    owner_d = sel;
                    idx_d   = '0;
                    acc_d   = 1'b1;
                    busy_d  = 1'b1;
                    gnt0_d  = ~sel;
                    gnt1_d  = sel;
                    xa_d    = op_a[0];
                    xb_d    = op_b[0];
                    a_d     = op_a >> 1;
                    b_d     = op_b >> 1;
                end
            end
            SHIFT: begin
                acc_d = acc_q & inXnY;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    eq_d    = acc_q & inXnY;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                    xa_d  = a_q[0];
                    xb_d  = b_q[0];
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign outGnt0  = gnt0_q;
    assign outGnt1  = gnt1_q;
    assign outBusy  = busy_q;
    assign outDone  = done_q;
    assign outEq    = eq_q;
    assign outOwner = owner_q;
    assign outXnA   = xa_q;
    assign outXnB   = xb_q;

endmodule
